// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch (IF) and memory (MEM) stages; data wins unless fetch has waited MAX_DATA_BURST grants.
// Optional watchdog abort compiled in with MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            IReqF,
    input  logic [AW-1:0]   IAddrF,
    output logic [DW-1:0]   IRdataF,
    output logic            IReadyF,
    input  logic            DReqM,
    input  logic            DWeM,
    input  logic [AW-1:0]   DAddrM,
    input  logic [DW-1:0]   DWdataM,
    input  logic [DW/8-1:0] DBeM,
    output logic [DW-1:0]   DRdataM,
    output logic            DReadyM,
    output logic            MemReq,
    output logic            MemWe,
    output logic [AW-1:0]   MemAddr,
    output logic [DW-1:0]   MemWdata,
    output logic [DW/8-1:0] MemBe,
    input  logic [DW-1:0]   MemRdata,
    input  logic            MemAck,
    output logic            StallFetch,
    output logic            StallMem,
    output logic            ErrTimeout
);

    if ((DW % 8) != 0) begin : g_dw_chk
        $error("DW must be a multiple of 8");
    end
    if (MAX_DATA_BURST < 1 || MAX_DATA_BURST > 15) begin : g_burst_chk
        $error("MAX_DATA_BURST must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

    state_t     r_state;
    logic [3:0] r_burst;
    logic       r_winner_d;

    logic w_fetch_forced;
    logic w_grant_d;

    // Fetch overrides data only once the burst budget is used up while it waits.
    assign w_fetch_forced = IReqF && (r_burst == BURST_MAX);
    assign w_grant_d      = DReqM && !w_fetch_forced;

    assign StallFetch = IReqF & ~IReadyF;
    assign StallMem   = DReqM & ~DReadyM;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] r_tmo;
`else
    assign ErrTimeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_burst    <= '0;
            r_winner_d <= 1'b0;
            MemReq     <= 1'b0;
            MemWe      <= 1'b0;
            MemAddr    <= '0;
            MemWdata   <= '0;
            MemBe      <= '0;
            IRdataF    <= '0;
            DRdataM    <= '0;
            IReadyF    <= 1'b0;
            DReadyM    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            ErrTimeout <= 1'b0;
            r_tmo      <= '0;
`endif
        end else begin
            IReadyF <= 1'b0;
            DReadyM <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            ErrTimeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state    <= DATA;
                        r_winner_d <= 1'b1;
                        MemReq     <= 1'b1;
                        MemWe      <= DWeM;
                        MemAddr    <= DAddrM;
                        MemWdata   <= DWdataM;
                        MemBe      <= DBeM;
                        if (!IReqF)
                            r_burst <= '0;
                        else if (r_burst != BURST_MAX)
                            r_burst <= r_burst + 4'd1;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_tmo <= '0;
`endif
                    end else if (IReqF) begin
                        r_state    <= FETCH;
                        r_winner_d <= 1'b0;
                        MemReq     <= 1'b1;
                        MemWe      <= 1'b0;
                        MemAddr    <= IAddrF;
                        MemWdata   <= '0;
                        MemBe      <= '1;
                        r_burst    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_tmo <= '0;
`endif
                    end
                end
                FETCH, DATA: begin
                    if (MemAck) begin
                        r_state <= DONE;
                        MemReq  <= 1'b0;
                        if (r_winner_d) begin
                            DRdataM <= MemRdata;
                            DReadyM <= 1'b1;
                        end else begin
                            IRdataF <= MemRdata;
                            IReadyF <= 1'b1;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // Abort completes the access with zero data so the stalled stage can move on.
                    else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_state    <= DONE;
                        MemReq     <= 1'b0;
                        ErrTimeout <= 1'b1;
                        if (r_winner_d) begin
                            DRdataM <= '0;
                            DReadyM <= 1'b1;
                        end else begin
                            IRdataF <= '0;
                            IReadyF <= 1'b1;
                        end
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle vector table plus starvation, timeout and reset sequences.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        IReqF, DReqM, DWeM, MemAck;
    logic [31:0] IAddrF, DAddrM, DWdataM, MemRdata;
    logic [3:0]  DBeM;
    logic [31:0] IRdataF, DRdataM, MemAddr, MemWdata;
    logic [3:0]  MemBe;
    logic        IReadyF, DReadyM, MemReq, MemWe, StallFetch, StallMem, ErrTimeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_DATA_BURST(4), .TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .Reset(Reset),
        .IReqF(IReqF), .IAddrF(IAddrF), .IRdataF(IRdataF), .IReadyF(IReadyF),
        .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM), .DBeM(DBeM),
        .DRdataM(DRdataM), .DReadyM(DReadyM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata), .MemBe(MemBe),
        .MemRdata(MemRdata), .MemAck(MemAck),
        .StallFetch(StallFetch), .StallMem(StallMem), .ErrTimeout(ErrTimeout)
    );

    typedef struct {
        logic        rst_n, ireq;  logic [31:0] iaddr;
        logic        dreq, dwe;    logic [31:0] daddr, dwdata; logic [3:0] dbe;
        logic        ack;          logic [31:0] mrdata;
        logic        chk_mem, e_req, e_we; logic [31:0] e_addr, e_wd; logic [3:0] e_be;
        logic        e_irdy;       logic [31:0] e_irdata;
        logic        e_drdy;       logic [31:0] e_drdata;
        logic        e_stf, e_stm;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_memreq(input string name);
        int t = 0;
        while (MemReq !== 1'b1 && t < 20) begin
            @(negedge CLK);
            t++;
        end
        check(name, {31'b0, MemReq}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit: got running, expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        string order;
        logic  is_d;

        // rst ireq iaddr      dreq dwe daddr       dwdata        dbe  ack mrdata        chk req we addr      wd            be   irdy irdata        drdy drdata        stf stm
        vec[0]  = '{0, 0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        0, 0};
        vec[1]  = '{1, 1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        1, 0};
        vec[2]  = '{1, 1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        1, 1, 0, 32'h100,  32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        1, 0};
        vec[3]  = '{1, 1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        1, 1, 0, 32'h100,  32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        1, 0};
        vec[4]  = '{1, 1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'hE3A00001, 1, 1, 0, 32'h100,  32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        1, 0};
        vec[5]  = '{1, 1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'hE3A00001, 0, 32'h0,        0, 0};
        vec[6]  = '{1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'hE3A00001, 0, 32'h0,        0, 0};
        vec[7]  = '{1, 1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'hE3A00001, 0, 32'h0,        1, 1};
        vec[8]  = '{1, 1, 32'h104, 1, 1, 32'h3000, 32'hDEADBEEF, 4'hF, 0, 32'h0,        1, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 32'hE3A00001, 0, 32'h0,        1, 1};
        vec[9]  = '{1, 1, 32'h104, 1, 1, 32'h3000, 32'hDEADBEEF, 4'hF, 1, 32'hA5A5A5A5, 1, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 32'hE3A00001, 0, 32'h0,        1, 1};
        vec[10] = '{1, 1, 32'h104, 1, 1, 32'h3000, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'hE3A00001, 1, 32'hA5A5A5A5, 1, 0};
        vec[11] = '{1, 1, 32'h104, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'hE3A00001, 0, 32'hA5A5A5A5, 1, 0};
        vec[12] = '{1, 1, 32'h104, 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'h12345678, 1, 1, 0, 32'h104,  32'h0,        4'h0, 0, 32'hE3A00001, 0, 32'hA5A5A5A5, 1, 0};
        vec[13] = '{1, 1, 32'h104, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'h12345678, 0, 32'hA5A5A5A5, 0, 0};
        vec[14] = '{1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 1, 32'hFFFFFFFF, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h12345678, 0, 32'hA5A5A5A5, 0, 0};
        vec[15] = '{1, 0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h12345678, 0, 32'hA5A5A5A5, 0, 0};

        Reset = 1'b0; IReqF = 1'b0; IAddrF = '0; DReqM = 1'b0; DWeM = 1'b0;
        DAddrM = '0; DWdataM = '0; DBeM = '0; MemAck = 1'b0; MemRdata = '0;
        repeat (2) @(posedge CLK);

        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            Reset = vec[i].rst_n; IReqF = vec[i].ireq; IAddrF = vec[i].iaddr;
            DReqM = vec[i].dreq; DWeM = vec[i].dwe; DAddrM = vec[i].daddr;
            DWdataM = vec[i].dwdata; DBeM = vec[i].dbe;
            MemAck = vec[i].ack; MemRdata = vec[i].mrdata;
            #1;
            check($sformatf("r%0d MemReq", i), {31'b0, MemReq}, {31'b0, vec[i].e_req});
            check($sformatf("r%0d IReadyF", i), {31'b0, IReadyF}, {31'b0, vec[i].e_irdy});
            check($sformatf("r%0d IRdataF", i), IRdataF, vec[i].e_irdata);
            check($sformatf("r%0d DReadyM", i), {31'b0, DReadyM}, {31'b0, vec[i].e_drdy});
            check($sformatf("r%0d DRdataM", i), DRdataM, vec[i].e_drdata);
            check($sformatf("r%0d StallFetch", i), {31'b0, StallFetch}, {31'b0, vec[i].e_stf});
            check($sformatf("r%0d StallMem", i), {31'b0, StallMem}, {31'b0, vec[i].e_stm});
            check($sformatf("r%0d ErrTimeout", i), {31'b0, ErrTimeout}, 32'd0);
            if (vec[i].chk_mem) begin
                check($sformatf("r%0d MemWe", i), {31'b0, MemWe}, {31'b0, vec[i].e_we});
                check($sformatf("r%0d MemAddr", i), MemAddr, vec[i].e_addr);
                if (vec[i].e_we) begin
                    check($sformatf("r%0d MemWdata", i), MemWdata, vec[i].e_wd);
                    check($sformatf("r%0d MemBe", i), {28'b0, MemBe}, {28'b0, vec[i].e_be});
                end
            end
        end

        // Starvation: both requesters held high; fetch gets every fifth grant.
        order = "DDDDFDDDDF";
        IReqF = 1'b1; IAddrF = 32'h104;
        DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h2000;
        for (int g = 0; g < 10; g++) begin
            @(negedge CLK);
            wait_memreq($sformatf("grant%0d wait", g));
            is_d = (MemAddr == 32'h2000);
            check($sformatf("grant%0d order", g), {24'b0, (is_d ? 8'h44 : 8'h46)}, {24'b0, order[g]});
            MemRdata = 32'h11110000 + 32'(g);
            MemAck = 1'b1;
            @(negedge CLK);
            MemAck = 1'b0;
            check($sformatf("grant%0d DReadyM", g), {31'b0, DReadyM}, {31'b0, order[g] == "D"});
            check($sformatf("grant%0d IReadyF", g), {31'b0, IReadyF}, {31'b0, order[g] == "F"});
            if (g == 9) begin
                IReqF = 1'b0; DReqM = 1'b0;
            end
        end

        // Access with no MemAck.
        @(negedge CLK);
        DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h40;
        @(negedge CLK);
        wait_memreq("tmo wait");
`ifdef MEM_ARB_TIMEOUT_EN
        repeat (7) @(negedge CLK);
        check("tmo early ErrTimeout", {31'b0, ErrTimeout}, 32'd0);
        check("tmo early MemReq", {31'b0, MemReq}, 32'd1);
        @(negedge CLK);
        check("tmo ErrTimeout", {31'b0, ErrTimeout}, 32'd1);
        check("tmo DReadyM", {31'b0, DReadyM}, 32'd1);
        check("tmo DRdataM", DRdataM, 32'd0);
        check("tmo MemReq", {31'b0, MemReq}, 32'd0);
        DReqM = 1'b0;
        @(negedge CLK);
        check("tmo pulse end", {31'b0, ErrTimeout}, 32'd0);
        check("tmo ready end", {31'b0, DReadyM}, 32'd0);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            check($sformatf("wait%0d ErrTimeout", k), {31'b0, ErrTimeout}, 32'd0);
        end
        check("wait MemReq held", {31'b0, MemReq}, 32'd1);
        MemRdata = 32'h55AA55AA; MemAck = 1'b1;
        @(negedge CLK);
        MemAck = 1'b0; DReqM = 1'b0;
        check("late ack DReadyM", {31'b0, DReadyM}, 32'd1);
        check("late ack DRdataM", DRdataM, 32'h55AA55AA);
`endif

        // Reset during DATA; a later MemAck must not complete anything.
        @(negedge CLK);
        DReqM = 1'b1; DWeM = 1'b0; DAddrM = 32'h2000;
        @(negedge CLK);
        wait_memreq("rst wait");
        Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1; DReqM = 1'b0;
        check("rst MemReq", {31'b0, MemReq}, 32'd0);
        check("rst DReadyM", {31'b0, DReadyM}, 32'd0);
        @(negedge CLK);
        MemRdata = 32'hDEAD0000; MemAck = 1'b1;
        @(negedge CLK);
        MemAck = 1'b0;
        check("rst ack DReadyM", {31'b0, DReadyM}, 32'd0);
        check("rst ack MemReq", {31'b0, MemReq}, 32'd0);
        @(negedge CLK);
        check("rst MemWe", {31'b0, MemWe}, 32'd0);
        check("rst MemAddr", MemAddr, 32'd0);
        check("rst MemWdata", MemWdata, 32'd0);
        check("rst MemBe", {28'b0, MemBe}, 32'd0);
        check("rst IRdataF", IRdataF, 32'd0);
        check("rst DRdataM", DRdataM, 32'd0);
        check("rst IReadyF", {31'b0, IReadyF}, 32'd0);
        check("rst DReadyM idle", {31'b0, DReadyM}, 32'd0);
        check("rst ErrTimeout", {31'b0, ErrTimeout}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
